// File: rtl/mips_gpio_display_if.sv
// mips_gpio_display_if: MIPS_System data-bus slice seen by the GPIO/display slave.
//   cs    : chip select, access this cycle
//   we    : 1 = write, 0 = read (qualified by cs)
//   addr  : word offset (byte address bits [4:2])
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read request
interface mips_gpio_display_if;
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, we, addr, wdata, input rdata);
    modport slave  (input cs, we, addr, wdata, output rdata);
endinterface

// File: rtl/mips_gpio_display.sv
// mips_gpio_display: memory-mapped GPIO slave driving HEX3..HEX0 and LEDG,
// sampling SW and BUTTON (synchronized, debounced, sticky press flags).
//
// Optional feature macro: GPIO_IRQ_EN (adds IRQMASK register and the irq line;
// when undefined IRQMASK reads 0, writes are ignored and irq is tied 0).
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : cs/we/addr/wdata in, rdata out (read latency 1)
//   sw_in[SW_WIDTH]    : raw switches, asynchronous
//   btn_in[3]          : raw buttons, active-low, asynchronous
//   hex3..hex0[7]      : segments {g,f,e,d,c,b,a}, active-low
//   ledg[LED_WIDTH]    : green LEDs, active-high
//   irq                : button interrupt request
//
// Register map (word offset):
//   0 HEXVAL [15:0]  1 LED  2 SW (RO)  3 BTN: [2:0] level RO, [6:4] flags W1C
//   4 BLANK [3:0]    5 IRQMASK [2:0]   6,7 reserved (read 0)
module mips_gpio_display #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SW_WIDTH        = 10,
    parameter int          LED_WIDTH       = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_gpio_display_if.slave   bus,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic [2:0]           btn_in,
    output logic [6:0]           hex3,
    output logic [6:0]           hex2,
    output logic [6:0]           hex1,
    output logic [6:0]           hex0,
    output logic [LED_WIDTH-1:0] ledg,
    output logic                 irq
);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [15:0]          hexval;
    logic [LED_WIDTH-1:0] led_r;
    logic [3:0]           blank;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic [2:0]           btn_s1, btn_s2;
    logic [2:0]           btn_lvl, lvl_d;
    logic [15:0]          btn_cnt [3];
    logic [15:0]          cnt_d   [3];
    logic [2:0]           flags;
    logic [2:0]           irqmask_rd;
    logic [31:0]          rd_word;

    logic       wr, rd;
    logic [2:0] btn_p, rise, w1c;

    // Every wdata bit is referenced here so partially-used bus bits stay lint-quiet.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.wdata};

    assign wr    = bus.cs & bus.we;
    assign rd    = bus.cs & ~bus.we;
    assign btn_p = ~btn_s2;  // buttons are active-low on the board
    assign w1c   = (wr && bus.addr == 3'd3) ? bus.wdata[6:4] : 3'b000;
    assign rise  = lvl_d & ~btn_lvl;

    // Debounce: the counter only runs while the synchronized button disagrees
    // with the debounced level; any agreement restarts the stability window.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        lvl_d = btn_lvl;
        cnt_d = btn_cnt;
        for (int i = 0; i < 3; i++) begin
            if (btn_p[i] != btn_lvl[i]) begin
                if (btn_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    lvl_d[i] = btn_p[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = btn_cnt[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.addr)
            3'd0: rd_word = {16'b0, hexval};
            3'd1: rd_word = 32'(led_r);
            3'd2: rd_word = 32'(sw_s2);
            3'd3: rd_word = {25'b0, flags, 1'b0, btn_lvl};
            3'd4: rd_word = {28'b0, blank};
            3'd5: rd_word = {29'b0, irqmask_rd};
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hexval    <= '0;
            led_r     <= '0;
            blank     <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_lvl   <= '0;
            flags     <= '0;
            bus.rdata <= '0;
            // NOTE: the counter array is three small flop registers, not a RAM, so it is reset here.
            for (int i = 0; i < 3; i++) btn_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sw_s1   <= sw_in;
            sw_s2   <= sw_s1;
            btn_s1  <= btn_in;
            btn_s2  <= btn_s1;
            btn_lvl <= lvl_d;
            btn_cnt <= cnt_d;
            // A press debounced on the same edge as a W1C clear survives.
            flags   <= (flags & ~w1c) | rise;
            if (wr) begin
                case (bus.addr)
                    3'd0: hexval <= bus.wdata[15:0];
                    3'd1: led_r  <= bus.wdata[LED_WIDTH-1:0];
                    3'd4: blank  <= bus.wdata[3:0];
                    default: ;
                endcase
            end
            if (rd) bus.rdata <= rd_word;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [2:0] irqmask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr && bus.addr == 3'd5) irqmask <= bus.wdata[2:0];
            irq <= |(flags & irqmask);
        end
    end

    assign irqmask_rd = irqmask;
`else
    assign irqmask_rd = '0;
    assign irq        = 1'b0;
`endif

    // Displays follow the registers directly: a write shows on the same edge.
    assign hex0 = blank[0] ? 7'b1111111 : seg7(hexval[3:0]);
    assign hex1 = blank[1] ? 7'b1111111 : seg7(hexval[7:4]);
    assign hex2 = blank[2] ? 7'b1111111 : seg7(hexval[11:8]);
    assign hex3 = blank[3] ? 7'b1111111 : seg7(hexval[15:12]);
    assign ledg = led_r;

endmodule
